// File: rtl/bit_copy_pkg.sv
// Shared types and helpers for the bit copy sequencer.
// Holds the FSM state enum and the index-width helper.
package bit_copy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DONE = 2'd2
  } bc_state_t;

  // Index width that stays at least 1 bit wide, even for BITS=1.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lowest_set_index.sv
// Priority encoder: index of the lowest set bit of i_vec.
// Ports: i_vec (in), o_idx (lowest set index), o_any (i_vec != 0).
module lowest_set_index
  import bit_copy_pkg::*;
#(
  parameter int BITS = 4,
  parameter int IDXW = clog2_min1(BITS)
) (
  input  logic [BITS-1:0] i_vec,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = BITS - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = IDXW'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bit_copy_sequencer.sv
// Sequenced per-bit copy: result[i] <= data[i] for masked lanes, one per cycle.
// Ports: clk, rst_n, start, data, mask -> ready, busy, done, idx, result.
module bit_copy_sequencer
  import bit_copy_pkg::*;
#(
  parameter int BITS = 4,
  parameter int IDXW = clog2_min1(BITS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [BITS-1:0] data,
  input  logic [BITS-1:0] mask,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [IDXW-1:0] idx,
  output logic [BITS-1:0] result
);

  bc_state_t       r_state;
  bc_state_t       w_state_nxt;
  logic [BITS-1:0] r_snap;
  logic [BITS-1:0] r_mask;
  logic [BITS-1:0] w_pend;
  logic [BITS-1:0] w_result;
  logic [IDXW-1:0] w_idx;
  logic            w_any;
  logic            w_ready;
  logic            w_busy;
  logic            w_done;
  logic            w_accept;
  logic            w_last;

  assign w_ready  = (r_state == IDLE);
  assign w_busy   = (r_state == COPY);
  assign w_done   = (r_state == DONE);
  assign w_accept = w_ready & start;

  // Clearing the lowest set bit leaves zero: this is the final lane.
  assign w_last = ((w_pend & (w_pend - BITS'(1))) == '0);

  lowest_set_index #(
    .BITS (BITS),
    .IDXW (IDXW)
  ) u_lsi (
    .i_vec (w_pend),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (mask != '0) ? COPY : DONE;
        end
      end
      COPY: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Snapshot of the operands; later input changes are invisible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap <= '0;
      r_mask <= '0;
    end else if (w_accept) begin
      r_snap <= data;
      r_mask <= mask;
    end
  end

  // One writer per lane; the shared index makes them mutually exclusive.
  for (genvar gi = 0; gi < BITS; gi++) begin : g_lane
    logic w_we;
    logic r_res;
    logic r_pnd;

    assign w_we = w_busy & w_any & (w_idx == IDXW'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_res <= 1'b0;
        r_pnd <= 1'b0;
      end else if (w_accept) begin
        r_pnd <= mask[gi];
      end else if (w_we) begin
        r_res <= r_snap[gi];
        r_pnd <= 1'b0;
      end
    end

    assign w_result[gi] = r_res;
    assign w_pend[gi]   = r_pnd;
  end

  assign ready  = w_ready;
  assign busy   = w_busy;
  assign done   = w_done;
  assign idx    = w_idx;
  assign result = w_result;

  always_comb begin
    if (rst_n) begin
      assert ($onehot({w_ready, w_busy, w_done}));
      assert (!w_done || (((w_result ^ r_snap) & r_mask) == '0));
      assert (!w_busy || (w_pend != '0));
    end
  end

endmodule

// File: tb/tb_bit_copy_sequencer.sv
// Directed plus randomized bench for bit_copy_sequencer (BITS=4).
// Expected values come from a lane-list model of the copy rules.
module tb_bit_copy_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] data;
  logic [3:0] mask;
  logic       ready;
  logic       busy;
  logic       done;
  logic [1:0] idx;
  logic [3:0] result;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] model_res;

  bit_copy_sequencer #(.BITS(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .data   (data),
    .mask   (mask),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .idx    (idx),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic r,
                           input logic b, input logic d);
    chk({tag, ".ready"}, 32'(ready), 32'(r));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
  endtask

  // One complete operation, starting at a negedge in IDLE.
  task automatic run_op(input logic [3:0] d, input logic [3:0] m,
                        input bit disturb);
    int lanes[$];
    for (int i = 0; i < 4; i++) if (m[i]) lanes.push_back(i);
    start = 1'b1;
    data  = d;
    mask  = m;
    @(negedge clk);
    start = 1'b0;
    foreach (lanes[c]) begin
      chk_flags("copy", 1'b0, 1'b1, 1'b0);
      chk("copy.idx", 32'(idx), 32'(lanes[c]));
      chk("copy.res", 32'(result), 32'(model_res));
      model_res[lanes[c]] = d[lanes[c]];
      if (disturb) begin
        start = 1'b1;
        data  = 4'($urandom);
        mask  = 4'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk_flags("done", 1'b0, 1'b0, 1'b1);
    chk("done.res", 32'(result), 32'(model_res));
    @(negedge clk);
    chk_flags("back", 1'b1, 1'b0, 1'b0);
    chk("back.res", 32'(result), 32'(model_res));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    data  = '0;
    mask  = '0;
    model_res = '0;
    repeat (2) @(negedge clk);
    chk_flags("rst", 1'b1, 1'b0, 1'b0);
    chk("rst.res", 32'(result), 32'h0);
    chk("rst.idx", 32'(idx), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'b1010, 4'b1111, 1'b0);
    chk("t1.res", 32'(result), 32'b1010);
    run_op(4'b0101, 4'b0110, 1'b0);
    chk("t2.res", 32'(result), 32'b1100);
    run_op(4'b1111, 4'b0000, 1'b0);
    chk("t3.res", 32'(result), 32'b1100);
    run_op(4'b1111, 4'b1111, 1'b1);
    chk("t4.res", 32'(result), 32'b1111);
    @(negedge clk);
    chk_flags("t4.once", 1'b1, 1'b0, 1'b0);

    // Reset mid-copy after lanes 0 and 1 are written.
    start = 1'b1;
    data  = 4'b0110;
    mask  = 4'b1111;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid.idx", 32'(idx), 32'h2);
    chk("mid.res", 32'(result), 32'b1110);
    #2 rst_n = 1'b0;
    #1;
    chk_flags("arst", 1'b1, 1'b0, 1'b0);
    chk("arst.res", 32'(result), 32'h0);
    chk("arst.idx", 32'(idx), 32'h0);
    #1 rst_n = 1'b1;
    model_res = '0;
    @(negedge clk);
    chk_flags("arst.after", 1'b1, 1'b0, 1'b0);
    run_op(4'b1001, 4'b1011, 1'b0);

    // Back-to-back: start held high is re-accepted in the first IDLE cycle.
    start = 1'b1;
    data  = 4'b0011;
    mask  = 4'b0011;
    repeat (3) @(negedge clk);
    chk_flags("b2b.done", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_flags("b2b.idle", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk_flags("b2b.again", 1'b0, 1'b1, 1'b0);
    chk("b2b.idx", 32'(idx), 32'h0);
    repeat (2) @(negedge clk);
    model_res[1:0] = 2'b11;
    chk_flags("b2b.done2", 1'b0, 1'b0, 1'b1);
    chk("b2b.res", 32'(result), 32'(model_res));
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      run_op(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
